// File: rtl/cordic_pkg.sv
// cordic_pkg: constants and types shared by the CORDIC_Vector source, pipeline and collector
package cordic_pkg;
  localparam int CORDIC_WIDTH = 32;
  localparam int CORDIC_LATENCY = 34;
  localparam logic [31:0] CORDIC_K = 32'h9b74;
  typedef logic signed [31:0] mag_t;
endpackage

// File: rtl/mag_fifo.sv
// mag_fifo: synchronous first-word-fall-through FIFO; head reads as zero while empty
module mag_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign rd_data = empty ? '0 : mem_q[rp_q];
  // a write into a full FIFO is only taken when the head leaves on the same edge
  always_comb begin
    rd = rd_en && !empty;
    wr = wr_en && (!full || rd);
    wp_d = wr ? wp_q + 1'b1 : wp_q;
    rp_d = rd ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = wr_data;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: entries are only visible through the pointers
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/cordic_mag_collector.sv
// cordic_mag_collector: tracks CORDIC_Vector samples with tokens and buffers magnitudes under credit control
module cordic_mag_collector import cordic_pkg::*; #(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           mag_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [$clog2(LATENCY):0]   inflight,
  output logic                       ovf
);
  localparam int IW = $clog2(LATENCY) + 1;
  logic [LATENCY-1:0] tok_q, tok_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic ovf_q, ovf_d;
  logic issue, arrival, pop, wr_en, empty, full;
  // a credit is owed to every sample in the pipe and every result in the FIFO
  assign s_ready = (32'(inflight_q) + 32'(fill)) < 32'(DEPTH);
  assign m_valid = !empty;
  assign inflight = inflight_q;
  assign ovf = ovf_q;
  // token line shift, inflight accounting and overflow detection
  always_comb begin
    issue = s_valid && s_ready;
    arrival = tok_q[LATENCY-1];
    pop = m_valid && m_ready;
    wr_en = arrival && (!full || pop);
    tok_d = {tok_q[LATENCY-2:0], issue};
    inflight_d = inflight_q + IW'(issue) - IW'(arrival);
    ovf_d = ovf_q || (arrival && full && !pop);
  end
  // state registers; reset drops every token so stale pipeline results are ignored
  always_ff @(posedge clk) begin
    if (RST) begin
      tok_q <= '0;
      inflight_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tok_q <= tok_d;
      inflight_q <= inflight_d;
      ovf_q <= ovf_d;
    end
  end
  mag_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(RST),
    .wr_en(wr_en),
    .wr_data(mag_in),
    .rd_en(m_ready),
    .rd_data(m_data),
    .empty(empty),
    .full(full),
    .count(fill)
  );
endmodule
